// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch/execute controller: address width,
// controller states, error codes and the PC increment.
package fetch_sequencer_pkg;

    localparam int INST_ADD_WIDTH = 32;
    localparam int PC_INC         = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_EXEC   = 2'b10,
        ST_HALTED = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_TIMEOUT  = 2'b01,
        ERR_MISALIGN = 2'b10
    } err_e;

endpackage

// File: rtl/next_pc_select.sv
// Next-PC priority mux (jump > branch > sequential) with a word-alignment
// check on whichever target wins.
module next_pc_select
    import fetch_sequencer_pkg::*;
#(
    parameter int AW = INST_ADD_WIDTH
) (
    input  logic [AW-1:0] pc,
    input  logic          jump,
    input  logic [AW-1:0] jump_target,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    output logic [AW-1:0] next_pc,
    output logic          misaligned
);

    always_comb begin
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end else begin
            // wraps naturally at 2^AW
            next_pc = pc + AW'(PC_INC);
        end
        misaligned = |next_pc[1:0];
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute controller: drives the instruction memory
// handshake, latches the fetched word and steers the PC register load.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [INST_ADD_WIDTH-1:0] PC,
    output logic [INST_ADD_WIDTH-1:0] PC_IN,
    output logic                      IMEM_REQ,
    input  logic                      IMEM_READY,
    input  logic [INST_WIDTH-1:0]     IMEM_RDATA,
    output logic [INST_WIDTH-1:0]     INST,
    output logic                      INST_VALID,
    output logic                      COMMIT,
    input  logic                      STALL,
    input  logic                      JUMP,
    input  logic [INST_ADD_WIDTH-1:0] JUMP_TARGET,
    input  logic                      BRANCH_TAKEN,
    input  logic [INST_ADD_WIDTH-1:0] BRANCH_TARGET,
    input  logic                      HALT,
    output logic [1:0]                ERR_CODE,
    output logic [31:0]               RETIRED
);

    localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    state_e                  state_q, state_d;
    err_e                    err_q, err_d;
    logic [CW-1:0]           wait_q, wait_d;
    logic [INST_WIDTH-1:0]   inst_q, inst_d;
    logic [31:0]             retired_q, retired_d;
    logic [INST_ADD_WIDTH-1:0] sel_pc;
    logic                    sel_misaligned;

    next_pc_select #(.AW(INST_ADD_WIDTH)) u_next_pc_select (
        .pc            (PC),
        .jump          (JUMP),
        .jump_target   (JUMP_TARGET),
        .branch_taken  (BRANCH_TAKEN),
        .branch_target (BRANCH_TARGET),
        .next_pc       (sel_pc),
        .misaligned    (sel_misaligned)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        wait_d  = '0;   // zero outside FETCH, so every FETCH entry starts clean
        inst_d  = inst_q;
        PC_IN   = PC;
        COMMIT  = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (IMEM_READY) begin
                    inst_d  = IMEM_RDATA;
                    state_d = ST_EXEC;
                end else if (wait_q == CW'(WAIT_LIMIT)) begin
                    if (err_q == ERR_NONE) err_d = ERR_TIMEOUT;
                    state_d = ST_HALTED;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            ST_EXEC: begin
                if (!STALL) begin
                    if (HALT) begin
                        COMMIT  = 1'b1;
                        state_d = ST_HALTED;
                    end else if (sel_misaligned) begin
                        if (err_q == ERR_NONE) err_d = ERR_MISALIGN;
                        state_d = ST_HALTED;
                    end else begin
                        PC_IN   = sel_pc;
                        COMMIT  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = state_q;
        endcase
        retired_d = retired_q + {31'b0, COMMIT};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            err_q     <= ERR_NONE;
            wait_q    <= '0;
            inst_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
            inst_q    <= inst_d;
            retired_q <= retired_d;
        end
    end

    assign IMEM_REQ   = (state_q == ST_FETCH);
    assign INST_VALID = (state_q == ST_EXEC);
    assign INST       = inst_q;
    assign ERR_CODE   = err_q;
    assign RETIRED    = retired_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle fetch/execute controller that sequences the program counter register and the instruction memory handshake. It computes the next PC for the PC register's load input and holds the PC on stalls, waits and halts. It captures the fetched instruction and flags the single execute cycle per instruction. It sits between the PC register, the instruction memory and the decode/branch logic of the processor core.

## Interface
- INST_ADD_WIDTH, 32 (from shared macros): PC / address width.
- INST_WIDTH, 32: instruction word width.
- WAIT_LIMIT, 15: maximum extra FETCH cycles tolerated with IMEM_READY low before timeout.
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-low reset.
- PC  input  INST_ADD_WIDTH  current PC from the PC register.
- PC_IN  output  INST_ADD_WIDTH  next PC, driven to the PC register load input (combinational).
- IMEM_REQ  output  1  instruction memory read request; address is PC.
- IMEM_READY  input  1  memory has valid data on IMEM_RDATA this cycle.
- IMEM_RDATA  input  INST_WIDTH  instruction read data.
- INST  output  INST_WIDTH  latched instruction.
- INST_VALID  output  1  high in the EXEC state.
- COMMIT  output  1  INST_VALID & ~STALL & no error; datapath write enables are qualified by it.
- STALL  input  1  hold the current instruction in EXEC.
- JUMP, JUMP_TARGET  input  1 / INST_ADD_WIDTH  jump redirect, sampled only in EXEC.
- BRANCH_TAKEN, BRANCH_TARGET  input  1 / INST_ADD_WIDTH  branch redirect, sampled only in EXEC.
- HALT  input  1  decoded halt instruction, sampled only in EXEC.
- ERR_CODE  output  2  sticky error code: 00 none, 01 memory timeout, 10 misaligned target.
- RETIRED  output  32  committed-instruction count.

## Operation
- **States:** IDLE, FETCH, EXEC, HALTED.
- **Reset values:** state IDLE; INST 0; ERR_CODE 00; RETIRED 0; wait counter 0. Reset is asynchronous and takes effect mid-operation from any state.
- **IDLE:** IMEM_REQ=0, PC_IN=PC. Always moves to FETCH next cycle.
- **FETCH:** IMEM_REQ=1, PC_IN=PC. The wait counter is cleared on entry.
  - IMEM_READY=1: load INST from IMEM_RDATA, go to EXEC.
  - IMEM_READY=0 and counter==WAIT_LIMIT: ERR_CODE=01, go to HALTED.
  - Otherwise: increment the counter.
- **EXEC:** INST_VALID=1.
  - STALL=1: PC_IN=PC, stay in EXEC, COMMIT=0, redirect inputs ignored.
  - STALL=0 and HALT=1: PC_IN=PC, COMMIT=1, go to HALTED.
  - STALL=0, no halt: next PC is JUMP_TARGET if JUMP, else BRANCH_TARGET if BRANCH_TAKEN, else PC+4. JUMP wins when both redirects are asserted.
  - Selected next PC with bits [1:0] ≠ 00: PC_IN=PC, COMMIT=0, ERR_CODE=10, go to HALTED.
  - Otherwise: PC_IN=next PC, COMMIT=1, go to FETCH.
- **HALTED:** IMEM_REQ=0, INST_VALID=0, PC_IN=PC. Only reset leaves this state.
- **Arithmetic:** PC+4 wraps modulo 2^INST_ADD_WIDTH, so 0xFFFFFFFC → 0x00000000. RETIRED increments on COMMIT and wraps at 2^32.
- **Error code:** ERR_CODE holds its first non-zero value until reset.

## Timing
- After RST rises: cycle 0 IDLE, cycle 1 FETCH with IMEM_REQ=1.
- **Zero-wait memory:** 2 cycles per instruction (FETCH, EXEC). The PC register updates at the end of EXEC.
- **Acceptance window:** IMEM_READY is accepted on any of the first WAIT_LIMIT+1 FETCH cycles. Timeout sets ERR_CODE at the edge ending FETCH cycle WAIT_LIMIT+1.
- **Combinational paths:** INST_VALID and IMEM_REQ decode registered state. PC_IN and COMMIT are combinational from state and EXEC-cycle inputs.
- **Output update times:** INST is valid from the first EXEC cycle until the next fetch accept. RETIRED and ERR_CODE change on the edge following the qualifying cycle.

## Structure
- **Shared macros file:** INST_ADD_WIDTH, state encodings (IDLE/FETCH/EXEC/HALTED), ERR_CODE values, the PC increment constant 4.
- **Sub-module `next_pc_select`:** combinational priority mux (jump/branch/PC+4) plus the alignment check. Everything else stays in fetch_sequencer.

## Test plan
- **Reset and zero-wait run:** reset, IMEM_READY tied 1, no redirects → PC_IN sequence 0x4, 0x8, 0xC at the end of each EXEC; RETIRED=3 after 6 cycles.
- **Memory wait and timeout:** READY delayed 3 cycles → 3 extra FETCH cycles, INST = supplied word. READY never asserted with WAIT_LIMIT=15 → ERR_CODE=01 after 16 FETCH cycles, then IMEM_REQ=0 forever.
- **Redirect priority:** JUMP=1 to 0x100 with BRANCH_TAKEN=1 to 0x200 → PC_IN=0x100. Branch alone to 0x200 → 0x200. Target 0x202 → ERR_CODE=10, PC unchanged, COMMIT=0.
- **Stall:** STALL high 4 cycles in EXEC with JUMP asserted → PC_IN=PC, COMMIT=0 each cycle. On STALL release the jump is taken once and RETIRED increments by 1.
- **Halt and wrap:** HALT in EXEC → COMMIT=1, then HALTED with IMEM_REQ=0 and PC frozen. PC=0xFFFFFFFC without redirect → PC_IN=0x00000000.
- **Reset mid-operation:** RST low during FETCH wait and during HALTED → immediate IDLE; ERR_CODE, RETIRED and INST all 0.
